// File: rtl/mult_ctrl.sv
// Sequencer for a pair of CE-gated pipelined multiplier IPs (signed/unsigned).
// Latches operands, steps the chosen IP for MULT_LAT cycles and presents the product as HI/LO.
module mult_ctrl #(
    parameter int unsigned MULT_LAT = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    input  logic        kill_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_ce_s_o,
    output logic        mul_ce_u_o,
    output logic        mul_sclr_o,
    input  logic [63:0] mul_p_s_i,
    input  logic [63:0] mul_p_u_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(MULT_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              sign_q, sign_d;
    logic              abort;
    logic [63:0]       prod;

    // A flush or a pending MEM exception both throw the multiply away.
    assign abort = flush_i | kill_i;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !abort) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    sign_d  = signed_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (abort || !hold_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
        end
    end

    // Stall and clear are gated by reset so a start or flush held during reset has no effect.
    assign stall_o    = rst_i & ~kill_i &
                        (((state_q == S_IDLE) & start_i) | (state_q == S_RUN));
    assign mul_sclr_o = rst_i & flush_i;

    assign mul_a_o    = a_q;
    assign mul_b_o    = b_q;
    assign mul_ce_s_o = (state_q == S_RUN) &  sign_q;
    assign mul_ce_u_o = (state_q == S_RUN) & ~sign_q;
    assign busy_o     = (state_q != S_IDLE);

    assign prod   = sign_q ? mul_p_s_i : mul_p_u_i;
    assign done_o = (state_q == S_DONE) & ~abort;
    assign hi_o   = done_o ? prod[63:32] : 32'd0;
    assign lo_o   = done_o ? prod[31:0]  : 32'd0;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: 9-stage CE-gated behavioural multipliers, directed vectors,
// a product scoreboard drained by an independent done_o monitor.
module tb_mult_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, signed_i, flush_i, kill_i, hold_i;
    logic [31:0] op_a_i, op_b_i;
    logic        stall_o, mul_ce_s_o, mul_ce_u_o, mul_sclr_o, done_o, busy_o;
    logic [31:0] mul_a_o, mul_b_o, hi_o, lo_o;
    logic [63:0] mul_p_s_i, mul_p_u_i;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic        mon_prev_done = 1'b0;
    logic [63:0] mon_cur = '0;
    logic [63:0] pipe_s [9];
    logic [63:0] pipe_u [9];

    always #5 clk_i = ~clk_i;

    mult_ctrl #(.MULT_LAT(9)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i), .kill_i(kill_i),
        .hold_i(hold_i), .stall_o(stall_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_ce_s_o(mul_ce_s_o), .mul_ce_u_o(mul_ce_u_o), .mul_sclr_o(mul_sclr_o),
        .mul_p_s_i(mul_p_s_i), .mul_p_u_i(mul_p_u_i), .hi_o(hi_o), .lo_o(lo_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Behavioural multiplier IPs: 9 pipeline stages advancing only on their CE.
    always @(posedge clk_i) begin
        if (mul_sclr_o) begin
            for (int i = 0; i < 9; i++) begin
                pipe_s[i] <= '0;
                pipe_u[i] <= '0;
            end
        end else begin
            if (mul_ce_s_o) begin
                pipe_s[0] <= smul(mul_a_o, mul_b_o);
                for (int i = 1; i < 9; i++) pipe_s[i] <= pipe_s[i-1];
            end
            if (mul_ce_u_o) begin
                pipe_u[0] <= umul(mul_a_o, mul_b_o);
                for (int i = 1; i < 9; i++) pipe_u[i] <= pipe_u[i-1];
            end
        end
    end
    assign mul_p_s_i = pipe_s[8];
    assign mul_p_u_i = pipe_u[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected product per done_o pulse and requires it stable while held.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (done_o) begin
                if (!mon_prev_done) begin
                    if (exp_q.size() == 0) check("spurious_done", 64'(done_o), 64'd0);
                    else mon_cur = exp_q.pop_front();
                end
                check("product", {hi_o, lo_o}, mon_cur);
            end else begin
                check("hi_lo_zero_when_idle", {hi_o, lo_o}, 64'd0);
            end
            mon_prev_done = done_o;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 64'(stall_o), 64'd0);
        check({tag, "_done"},  64'(done_o),  64'd0);
        check({tag, "_busy"},  64'(busy_o),  64'd0);
        check({tag, "_ce"},    64'({mul_ce_s_o, mul_ce_u_o}), 64'd0);
        check({tag, "_sclr"},  64'(mul_sclr_o), 64'd0);
        check({tag, "_hilo"},  {hi_o, lo_o}, 64'd0);
        check({tag, "_opnds"}, {mul_a_o, mul_b_o}, 64'd0);
    endtask

    // One multiply with start_i held through RUN; operand/sign inputs are scrambled mid-RUN.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int hold_cycles,
                          input int exp_ce_s, input int exp_ce_u, input string tag);
        int stall_n = 0;
        int ces = 0;
        int ceu = 0;
        bit seen = 0;
        exp_q.push_back(exp);
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b1; signed_i = sgn; op_a_i = a; op_b_i = b;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done_o) begin
                seen = 1;
                break;
            end
            stall_n += int'(stall_o);
            ces     += int'(mul_ce_s_o);
            ceu     += int'(mul_ce_u_o);
            if (i == 1) begin
                op_a_i = ~a; op_b_i = ~b; signed_i = ~sgn;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        hold_i  = (hold_cycles > 0);
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_stall_cycles"}, 64'(stall_n), 64'd10);
        check({tag, "_ce_s_cycles"}, 64'(ces), 64'(exp_ce_s));
        check({tag, "_ce_u_cycles"}, 64'(ceu), 64'(exp_ce_u));
        check({tag, "_opnds_latched"}, {mul_a_o, mul_b_o}, {a, b});
        for (int k = 1; k <= hold_cycles; k++) begin
            @(negedge clk_i);
            #1;
            check({tag, "_held_done"}, 64'(done_o), 64'd1);
            hold_i = (k < hold_cycles);
        end
        @(negedge clk_i);
        #1;
        check({tag, "_back_idle"}, 64'({busy_o, done_o}), 64'd0);
    endtask

    initial begin
        int stall_n;
        int dn;
        rst_i = 1'b0; start_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
        kill_i = 1'b0; hold_i = 1'b0; op_a_i = '0; op_b_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check_quiet("in_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_quiet("after_reset");

        // MULTU 0xFFFFFFFF x 2 and MULT -2 x 3.
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, 0, 0, 9, "multu");
        run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 0, 9, 0, "mult");

        // Flush on the 4th RUN cycle.
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b0; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h0000_0010;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        check("flush_sclr", 64'(mul_sclr_o), 64'd1);
        check("flush_busy_in_run", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("flush_to_idle", 64'({busy_o, stall_o, mul_sclr_o}), 64'd0);
        repeat (14) @(negedge clk_i);

        // hold_i for 3 cycles in DONE.
        run_op(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, 3, 0, 9, "hold");

        // kill_i in the start cycle.
        @(negedge clk_i);
        start_i = 1'b1; kill_i = 1'b1; op_a_i = 32'hAAAA_5555;
        #1;
        check("kill_start_stall", 64'(stall_o), 64'd0);
        @(negedge clk_i);
        start_i = 1'b0; kill_i = 1'b0;
        #1;
        check("kill_start_busy", 64'(busy_o), 64'd0);
        check("kill_start_opnd", 64'(mul_a_o), 64'h1234_5678);

        // Reset while RUN has cnt == 5.
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b0; op_a_i = 32'd7; op_b_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("pre_reset_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b0;
        #1;
        check_quiet("mid_run_reset");
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b1; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'd5;
        #1;
        check_quiet("reset_start_high");
        run_op(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 9, 0, "post_reset");

        // start_i held across DONE launches a second multiply.
        exp_q.push_back(64'h0000_0000_0000_000F);
        exp_q.push_back(64'h0000_0000_0000_000F);
        stall_n = 0;
        dn = 0;
        @(negedge clk_i);
        start_i = 1'b1; signed_i = 1'b0; op_a_i = 32'd3; op_b_i = 32'd5;
        for (int i = 0; i < 60; i++) begin
            #1;
            stall_n += int'(stall_o);
            dn      += int'(done_o);
            if (dn == 2) begin
                start_i = 1'b0;
                break;
            end
            @(negedge clk_i);
        end
        check("b2b_done_count", 64'(dn), 64'd2);
        check("b2b_stall_cycles", 64'(stall_n), 64'd20);
        @(negedge clk_i);
        #1;
        check("b2b_idle", 64'(busy_o), 64'd0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
